// File: rtl/pll_sup_pkg.sv
// Shared state encoding, counter widths and width helper for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_PWRDN,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAULT
  } pll_state_e;

  localparam int LOSS_CNT_W  = 8;
  localparam int RETRY_CNT_W = 4;

  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width = width + 1;
    return width;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; output is 0 while in reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL power-up sequencer: lock timeout, stability qualification, bounded retries, fault latch.
// Build option LOCK_DEGLITCH_EN: in RUN, only DEGLITCH_CYCLES consecutive unlocked cycles count as loss.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int PWRDN_CYCLES    = 16,
  parameter int LOCK_TIMEOUT    = 65535,
  parameter int STABLE_CYCLES   = 1024,
  parameter int MAX_RETRIES     = 3,
  parameter int DEGLITCH_CYCLES = 4
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   ENABLE,
  input  logic                   CLEAR_FAULT,
  input  logic                   PLL_LOCK,
  output logic                   PLL_POWERDOWN_N,
  output logic                   FABRIC_RESET_N,
  output logic                   READY,
  output logic                   FAULT,
  output logic [RETRY_CNT_W-1:0] RETRY_CNT,
  output logic [LOSS_CNT_W-1:0]  LOSS_CNT
);

  localparam int MAX_A   = (PWRDN_CYCLES > LOCK_TIMEOUT) ? PWRDN_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_B   = (STABLE_CYCLES > DEGLITCH_CYCLES) ? STABLE_CYCLES : DEGLITCH_CYCLES;
  localparam int MAX_P   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TIMER_W = clog2(MAX_P + 1);

  localparam logic [TIMER_W-1:0]     PWRDN_LAST   = TIMER_W'(PWRDN_CYCLES - 1);
  localparam logic [TIMER_W-1:0]     TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT);
  localparam logic [TIMER_W-1:0]     STABLE_LAST  = TIMER_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_CNT_W-1:0] RETRY_LIMIT  = RETRY_CNT_W'(MAX_RETRIES);

  function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
    return (&v) ? v : v + LOSS_CNT_W'(1);
  endfunction

  pll_state_e             state_q, state_nxt;
  logic [TIMER_W-1:0]     timer_q, timer_nxt;
  logic [RETRY_CNT_W-1:0] retry_q, retry_nxt;
  logic [LOSS_CNT_W-1:0]  loss_q, loss_nxt;
  logic                   lock_s;
  logic                   fail;
  logic                   loss_evt;

`ifdef LOCK_DEGLITCH_EN
  localparam int              DG_W    = clog2(DEGLITCH_CYCLES + 1);
  localparam logic [DG_W-1:0] DG_LAST = DG_W'(DEGLITCH_CYCLES - 1);
  logic [DG_W-1:0] dg_q, dg_nxt;
`endif

  sync_2ff u_lock_sync (
    .clk   (CLK),
    .rst_n (RESET_N),
    .d     (PLL_LOCK),
    .q     (lock_s)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= ST_PWRDN;
    else          state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    timer_nxt = timer_q + TIMER_W'(1);
    retry_nxt = retry_q;
    loss_nxt  = loss_q;
    fail      = 1'b0;
    loss_evt  = 1'b0;
`ifdef LOCK_DEGLITCH_EN
    dg_nxt    = '0;
`endif
    case (state_q)
      ST_PWRDN:
        if (timer_q == PWRDN_LAST) state_nxt = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (lock_s) state_nxt = ST_STABLE;
        else if (timer_q == TIMEOUT_LAST) fail = 1'b1;
      end
      ST_STABLE: begin
        if (!lock_s) fail = 1'b1;
        else if (timer_q == STABLE_LAST) state_nxt = ST_RUN;
      end
      ST_RUN: begin
`ifdef LOCK_DEGLITCH_EN
        if (!lock_s) begin
          if (dg_q == DG_LAST) loss_evt = 1'b1;
          else                 dg_nxt   = dg_q + DG_W'(1);
        end
`else
        loss_evt = !lock_s;
`endif
      end
      ST_FAULT:
        if (CLEAR_FAULT) begin
          state_nxt = ST_PWRDN;
          retry_nxt = '0;
        end
      default: state_nxt = ST_PWRDN;
    endcase

    // Event priority: disable overrides loss/fail, which override timer expiry.
    if (fail) begin
      retry_nxt = retry_q + RETRY_CNT_W'(1);
      state_nxt = (retry_nxt == RETRY_LIMIT) ? ST_FAULT : ST_PWRDN;
    end
    if (loss_evt) begin
      loss_nxt  = sat_inc(loss_q);
      retry_nxt = '0;
      state_nxt = ST_PWRDN;
    end
    if (!ENABLE && state_q != ST_FAULT) begin
      state_nxt = ST_PWRDN;
      retry_nxt = '0;
      loss_nxt  = loss_q;
`ifdef LOCK_DEGLITCH_EN
      dg_nxt    = '0;
`endif
    end

    if (state_nxt != state_q || state_q == ST_RUN || state_q == ST_FAULT || !ENABLE)
      timer_nxt = '0;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      timer_q         <= '0;
      retry_q         <= '0;
      loss_q          <= '0;
      PLL_POWERDOWN_N <= 1'b0;
      FABRIC_RESET_N  <= 1'b0;
      READY           <= 1'b0;
      FAULT           <= 1'b0;
    end else begin
      timer_q         <= timer_nxt;
      retry_q         <= retry_nxt;
      loss_q          <= loss_nxt;
      PLL_POWERDOWN_N <= (state_nxt == ST_WAIT_LOCK) || (state_nxt == ST_STABLE) ||
                         (state_nxt == ST_RUN);
      FABRIC_RESET_N  <= (state_nxt == ST_RUN);
      READY           <= (state_nxt == ST_RUN);
      FAULT           <= (state_nxt == ST_FAULT);
    end
  end

`ifdef LOCK_DEGLITCH_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) dg_q <= '0;
    else          dg_q <= dg_nxt;
  end
`endif

  assign RETRY_CNT = retry_q;
  assign LOSS_CNT  = loss_q;

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
Controls the fabric PLL, which is the other end of the PLL's PLL_POWERDOWN_N_0/PLL_LOCK_0 interface. It sequences PLL power-up, waits for lock within a timeout, and requires lock to stay stable before it releases a fabric reset. It detects loss of lock, retries a bounded number of times and then latches a fault. It runs on a free-running reference-domain clock, never on a PLL output, and its outputs feed the top-level reset tree and status registers.

Parameters:
PWRDN_CYCLES, 16, cycles PLL_POWERDOWN_N is held low per attempt (>=2)
LOCK_TIMEOUT, 65535, max cycles in WAIT_LOCK before the attempt fails
STABLE_CYCLES, 1024, consecutive locked cycles required before READY
MAX_RETRIES, 3, failed attempts allowed before FAULT (1..15)
DEGLITCH_CYCLES, 4, consecutive unlocked cycles that count as loss (LOCK_DEGLITCH_EN only)

Ports:
CLK  in  1  free-running reference clock
RESET_N  in  1  asynchronous active-low reset
ENABLE  in  1  level; 0 forces PLL power-down
CLEAR_FAULT  in  1  single-cycle pulse; exits FAULT
PLL_LOCK  in  1  PLL lock, asynchronous to CLK
PLL_POWERDOWN_N  out  1  to PLL; 0 = powered down
FABRIC_RESET_N  out  1  registered reset release for the PLL clock domains
READY  out  1  PLL locked and stable
FAULT  out  1  retries exhausted
RETRY_CNT  out  4  failed attempts in the current sequence
LOSS_CNT  out  8  lock-loss events after READY, saturating at 255

Behaviour:
- Reset values: PLL_POWERDOWN_N=0, FABRIC_RESET_N=0, READY=0, FAULT=0, RETRY_CNT=0, LOSS_CNT=0, state=PWRDN, all timers=0.
- PLL_LOCK passes through a 2-FF synchronizer (lock_s). Only lock_s is used, so lock response latency is 2 cycles.
- All outputs are registered directly from state or counter flops, with no combinational paths to outputs.
- A single shared timer (width = clog2 of the largest parameter) reloads to 0 on every state transition.
- PWRDN: PLL_POWERDOWN_N=0. After PWRDN_CYCLES cycles with ENABLE=1, go to WAIT_LOCK.
- WAIT_LOCK: PLL_POWERDOWN_N=1.
  - lock_s=1 -> STABLE.
  - Timer reaches LOCK_TIMEOUT -> fail.
- STABLE: lock_s must stay 1 for STABLE_CYCLES consecutive cycles -> RUN. Any 0 -> fail.
- RUN: READY=1 and FABRIC_RESET_N=1, both starting the cycle after RUN is entered. A loss event gives LOSS_CNT+=1 (saturating), READY=0, FABRIC_RESET_N=0, RETRY_CNT=0, then PWRDN.
- Fail: RETRY_CNT+=1.
  - If the new value equals MAX_RETRIES -> FAULT state.
  - Otherwise -> PWRDN.
- FAULT: FAULT=1, PLL_POWERDOWN_N=0, FABRIC_RESET_N=0. CLEAR_FAULT gives FAULT=0, RETRY_CNT=0, then PWRDN.
- ENABLE=0 in any state except FAULT: go to PWRDN next cycle, READY=0, FABRIC_RESET_N=0, RETRY_CNT=0. LOSS_CNT is not incremented.
- ENABLE=0 in FAULT: stay in FAULT.
- Priority when events coincide: ENABLE=0 > loss/fail > timer expiry.
- CLEAR_FAULT outside FAULT: ignored.
- CLEAR_FAULT and ENABLE=0 in the same cycle while in FAULT: fault clears, next state is PWRDN, which holds until ENABLE=1.
- RETRY_CNT holds its value while in RUN. It clears only on entering PWRDN from RUN, on ENABLE=0, or on CLEAR_FAULT.
- Asserting RESET_N mid-sequence returns every output to its reset value immediately.
- FABRIC_RESET_N deasserts only from RUN and asserts asynchronously with RESET_N.

Optional Feature:
LOCK_DEGLITCH_EN
- Defined: in RUN, a loss event is lock_s=0 for DEGLITCH_CYCLES consecutive cycles. Shorter drops are ignored and READY stays 1. Uses a separate deglitch counter that clears whenever lock_s=1.
- Undefined: a single cycle of lock_s=0 in RUN is a loss event. DEGLITCH_CYCLES is unused.
- STABLE is strict in both builds.

Decomposition:
- Package pll_sup_pkg holds:
  - state enum (PWRDN, WAIT_LOCK, STABLE, RUN, FAULT)
  - LOSS_CNT_W=8 and RETRY_CNT_W=4 constants
  - the clog2 helper function
- Sub-module sync_2ff (1-bit, async active-low reset, output 0 in reset) for PLL_LOCK, reusable elsewhere.

Test Plan:
All scenarios use PWRDN_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=3, DEGLITCH_CYCLES=4.
1. Normal lock: ENABLE=1, PLL_LOCK rises 6 cycles after PLL_POWERDOWN_N rises -> READY=1 and FABRIC_RESET_N=1 exactly 2+8+1 cycles after the lock edge; RETRY_CNT=0.
2. Timeout to fault: PLL_LOCK held 0 -> three power-down/attempt cycles, 21 cycles each in WAIT_LOCK; then FAULT=1, RETRY_CNT=3, PLL_POWERDOWN_N=0. CLEAR_FAULT -> FAULT=0, RETRY_CNT=0, new PWRDN.
3. Unstable lock: PLL_LOCK drops for 1 cycle at STABLE cycle 5 -> RETRY_CNT=1, return to PWRDN; relock is clean -> READY=1 with RETRY_CNT=1 held.
4. Loss in RUN: PLL_LOCK low for 2 cycles -> with macro, READY stays 1 and LOSS_CNT=0; without macro, READY=0 and LOSS_CNT=1. Then a 5-cycle drop -> loss in both builds.
5. LOSS_CNT saturation: 260 loss/relock events -> LOSS_CNT=255.
6. Disable and reset mid-sequence: ENABLE=0 during STABLE -> PWRDN next cycle, RETRY_CNT=0, LOSS_CNT unchanged. RESET_N=0 in RUN -> all outputs at reset values in the same cycle.
